// File: rtl/fa_24_seq_pkg.sv
// Shared mantissa-datapath constants and the sequential adder state type.
package fa_24_seq_pkg;

   localparam int MANT_WIDTH  = 24;
   localparam int SLICE_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/fa_24_seq_fa_8.sv
// Combinational slice adder: {cout, out} = a + b + cin.
module fa_8
   import fa_24_seq_pkg::*;
#(
   parameter int WIDTH = SLICE_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] out,
   output logic             cout
);

   assign {cout, out} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/fa_24_seq.sv
// Multi-cycle mantissa adder: one shared slice adder walks the operands LSB
// slice first, with valid/ready handshakes on both sides.
module fa_24_seq
   import fa_24_seq_pkg::*;
#(
   parameter int DATA_WIDTH  = MANT_WIDTH,
   parameter int SLICE_WIDTH = fa_24_seq_pkg::SLICE_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   input  logic                  cin,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out,
   output logic                  cout,
   output logic                  busy
);

   localparam int NUM_SLICES = DATA_WIDTH / SLICE_WIDTH;
   localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

   state_e                  state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic                    c_q, c_d;
   logic [DATA_WIDTH-1:0]   a_q, a_d;
   logic [DATA_WIDTH-1:0]   b_q, b_d;
   logic [DATA_WIDTH-1:0]   out_q, out_d;
   logic                    cout_q, cout_d;

   logic [SLICE_WIDTH-1:0]  slice_a, slice_b, slice_sum;
   logic                    slice_cout;
   logic                    accept;

   // Combinational path from out_ready lets a new operand enter on the
   // same edge the previous result leaves.
   assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
   assign accept    = in_valid & in_ready;
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q == CALC);
   assign out       = out_q;
   assign cout      = cout_q;

   assign slice_a = a_q[idx_q*SLICE_WIDTH +: SLICE_WIDTH];
   assign slice_b = b_q[idx_q*SLICE_WIDTH +: SLICE_WIDTH];

   fa_8 #(
      .WIDTH (SLICE_WIDTH)
   ) u_fa_8 (
      .a    (slice_a),
      .b    (slice_b),
      .cin  (c_q),
      .out  (slice_sum),
      .cout (slice_cout)
   );

   always_comb begin
      // NOTE: every variable gets a hold-value default first, so no path
      // through the case leaves one unassigned and no latch is inferred.
      state_d = state_q;
      idx_d   = idx_q;
      c_d     = c_q;
      a_d     = a_q;
      b_d     = b_q;
      out_d   = out_q;
      cout_d  = cout_q;

      case (state_q)
         IDLE: ;
         CALC: begin
            out_d[idx_q*SLICE_WIDTH +: SLICE_WIDTH] = slice_sum;
            c_d = slice_cout;
            if (idx_q == LAST_IDX) begin
               cout_d  = slice_cout;
               idx_d   = '0;
               state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // accept is only possible in IDLE or in DONE while the result drains
      if (accept) begin
         a_d     = a;
         b_d     = b;
         c_d     = cin;
         idx_d   = '0;
         state_d = CALC;
      end
   end

   // NOTE: state uses non-blocking assignments so every flop samples the
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         c_q     <= 1'b0;
         // NOTE: operand registers are cleared too; they are few and a
         // known value keeps post-reset simulation free of X.
         a_q     <= '0;
         b_q     <= '0;
         out_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         c_q     <= c_d;
         a_q     <= a_d;
         b_q     <= b_d;
         out_q   <= out_d;
         cout_q  <= cout_d;
      end
   end

endmodule

// File: tb/tb_fa_24_seq.sv
// Directed bench for fa_24_seq: table of add vectors plus handshake corner cases.
module tb_fa_24_seq;

   localparam int W = 24;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic         cin = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         in_ready, out_valid, cout, busy;
   logic [W-1:0] out;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] exp_out;
      logic         exp_cout;
   } vec_t;

   vec_t vecs[10];

   always #5 clk = ~clk;

   fa_24_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .cout      (cout),
      .busy      (busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One transaction with out_ready high: checks CALC window, latency, result, drain.
   task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                         input logic [W-1:0] eo, input logic ec, input int id);
      int n;
      @(negedge clk);
      a = va; b = vb; cin = vc; in_valid = 1'b1; out_ready = 1'b1;
      check($sformatf("v%0d in_ready_idle", id), {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (out_valid !== 1'b1 && n < 8) begin
         check($sformatf("v%0d calc_busy", id), {31'd0, busy}, 32'd1);
         check($sformatf("v%0d calc_in_ready", id), {31'd0, in_ready}, 32'd0);
         n++;
         @(negedge clk);
      end
      check($sformatf("v%0d latency", id), n, 32'd3);
      check($sformatf("v%0d out", id), {8'd0, out}, {8'd0, eo});
      check($sformatf("v%0d cout", id), {31'd0, cout}, {31'd0, ec});
      @(negedge clk);
      check($sformatf("v%0d valid_drop", id), {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int pulses;
      int n;

      vecs[0] = '{24'h000001, 24'hFFFFFF, 1'b0, 24'h000000, 1'b1};
      vecs[1] = '{24'h123456, 24'h654321, 1'b1, 24'h777778, 1'b0};
      vecs[2] = '{24'h000000, 24'h000000, 1'b0, 24'h000000, 1'b0};
      vecs[3] = '{24'h000000, 24'h000000, 1'b1, 24'h000001, 1'b0};
      vecs[4] = '{24'h7FFFFF, 24'h000001, 1'b0, 24'h800000, 1'b0};
      vecs[5] = '{24'h0000FF, 24'h000001, 1'b0, 24'h000100, 1'b0};
      vecs[6] = '{24'h00FFFF, 24'h000000, 1'b1, 24'h010000, 1'b0};
      vecs[7] = '{24'h800000, 24'h800000, 1'b0, 24'h000000, 1'b1};
      vecs[8] = '{24'hFFFFFF, 24'h000000, 1'b1, 24'h000000, 1'b1};
      vecs[9] = '{24'hABCDEF, 24'h111111, 1'b0, 24'hBCDF00, 1'b0};

      // Reset state, asserted from time zero
      #1;
      check("rst out", {8'd0, out}, 32'd0);
      check("rst cout", {31'd0, cout}, 32'd0);
      check("rst out_valid", {31'd0, out_valid}, 32'd0);
      check("rst busy", {31'd0, busy}, 32'd0);
      #20;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post_rst out_valid", {31'd0, out_valid}, 32'd0);
      check("post_rst in_ready", {31'd0, in_ready}, 32'd1);

      for (int i = 0; i < 10; i++)
         run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp_out, vecs[i].exp_cout, i);

      // Back-to-back with in_valid and out_ready held high
      @(negedge clk);
      a = 24'h000010; b = 24'h000020; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      pulses = 0;
      for (int t = 1; t <= 11; t++) begin
         @(negedge clk);
         if (t == 1) begin
            a = 24'h800000; b = 24'h800000;
         end
         if (out_valid === 1'b1) pulses++;
         if (t == 4) begin
            check("b2b first_valid", {31'd0, out_valid}, 32'd1);
            check("b2b first_out", {8'd0, out}, 32'h000030);
            check("b2b first_cout", {31'd0, cout}, 32'd0);
         end
         if (t == 5) in_valid = 1'b0;
         if (t == 8) begin
            check("b2b second_valid", {31'd0, out_valid}, 32'd1);
            check("b2b second_out", {8'd0, out}, 32'h000000);
            check("b2b second_cout", {31'd0, cout}, 32'd1);
         end
      end
      check("b2b pulse_count", pulses, 32'd2);

      // Backpressure hold: result stable, in_valid ignored
      @(negedge clk);
      a = 24'hFFFFFF; b = 24'hFFFFFF; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (out_valid !== 1'b1 && n < 8) begin
         n++;
         @(negedge clk);
      end
      check("hold latency", n, 32'd3);
      for (int i = 0; i < 5; i++) begin
         check("hold out_valid", {31'd0, out_valid}, 32'd1);
         check("hold out", {8'd0, out}, 32'h00FFFFFF);
         check("hold cout", {31'd0, cout}, 32'd1);
         check("hold in_ready", {31'd0, in_ready}, 32'd0);
         in_valid = (i % 2 == 0);
         a = 24'(i); b = 24'h000001; cin = 1'b0;
         @(negedge clk);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      check("release valid_drop", {31'd0, out_valid}, 32'd0);
      check("release in_ready", {31'd0, in_ready}, 32'd1);
      check("release busy", {31'd0, busy}, 32'd0);

      // Reset in the second CALC cycle aborts the operation
      @(negedge clk);
      a = 24'hABCDEF; b = 24'h111111; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check("abort first_calc busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
      check("abort partial_out", {8'd0, out}, 32'h00FFFF00);
      rst_n = 1'b0;
      #1;
      check("abort out", {8'd0, out}, 32'd0);
      check("abort cout", {31'd0, cout}, 32'd0);
      check("abort out_valid", {31'd0, out_valid}, 32'd0);
      check("abort busy", {31'd0, busy}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("abort post_rst out_valid", {31'd0, out_valid}, 32'd0);
      check("abort post_rst in_ready", {31'd0, in_ready}, 32'd1);
      pulses = 0;
      repeat (5) begin
         @(negedge clk);
         if (out_valid === 1'b1) pulses++;
      end
      check("abort no_valid", pulses, 32'd0);

      run_op(24'h000001, 24'h000001, 1'b0, 24'h000002, 1'b0, 100);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
